// File: rtl/dac7611_pkg.sv
// Shared definitions for the DAC7611 serial receiver.
//  - DATA_W_DEF   : default frame width (bits per DAC code)
//  - IDX_*        : bit positions inside the 4-bit serial bundle {CLK,SDI,LD,CLR}
//  - IDLE_BUNDLE  : bundle value of a quiet link (CLK high, LD/CLR released)
//  - state_t      : receiver FSM encoding
//  - cnt_sat_inc  : bit counter increment that saturates at its maximum
package dac7611_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int CNT_W      = 5;

  localparam int IDX_CLK = 3;
  localparam int IDX_SDI = 2;
  localparam int IDX_LD  = 1;
  localparam int IDX_CLR = 0;

  localparam logic [3:0] IDLE_BUNDLE = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/dac7611_serial_rx_sync.sv
// Synchroniser plus edge detector for one line of the serial bundle.
// Ports:
//  clk, reset : fabric clock, synchronous active-high reset
//  din        : asynchronous input line
//  level      : synchronised line value
//  rise, fall : single-cycle edge events derived from the synchronised value
// The chain and the edge flop reset to RESET_VAL so a quiet link produces
// no spurious edge when reset is released.
module dac_sig_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= {SYNC_STAGES{RESET_VAL}};
      prev_reg <= RESET_VAL;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/dac7611_serial_rx.sv
// Receiving end of the DAC7611 3-wire serial link, oversampled on clk.
// Rebuilds the code a DAC7611 would latch and flags badly framed loads.
// Ports:
//  clk, reset      : fabric clock (>= 4x serial CLK), synchronous active-high reset
//  dac_signals_15  : {CLK,SDI,LD,CLR}, asynchronous, LD and CLR active low
//  dac_code        : last latched code
//  code_valid      : 1-cycle pulse when dac_code is updated by a load
//  frame_err       : 1-cycle pulse when a load saw a bit count other than DATA_W
//  clr_seen        : CLR currently asserted (synchronised)
//  bit_cnt         : bits shifted since the last load/clear, saturating at 31
module dac7611_serial_rx
  import dac7611_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        dac_signals_15,
  output logic [DATA_W-1:0] dac_code,
  output logic              code_valid,
  output logic              frame_err,
  output logic              clr_seen,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic [3:0] lvl, rise, fall;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_line
      dac_sig_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (IDLE_BUNDLE[gi])
      ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (dac_signals_15[gi]),
        .level (lvl[gi]),
        .rise  (rise[gi]),
        .fall  (fall[gi])
      );
    end
  endgenerate

  logic clk_rise, sdi_s, ld_fall, ld_rise, clr_n;
  assign clk_rise = rise[IDX_CLK];
  assign sdi_s    = lvl[IDX_SDI];
  assign ld_fall  = fall[IDX_LD];
  assign ld_rise  = rise[IDX_LD];
  assign clr_n    = lvl[IDX_CLR];

  // Edge/level outputs of the generic line block that the receiver never needs.
  logic unused_events;
  assign unused_events = ^{lvl[IDX_CLK], lvl[IDX_LD], fall[IDX_CLK], rise[IDX_SDI],
                           fall[IDX_SDI], rise[IDX_CLR], fall[IDX_CLR]};

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  shreg_reg, shreg_next;
  logic [CNT_W-1:0]   bit_cnt_reg, cnt_next;
  logic [DATA_W-1:0]  dac_code_reg, code_next;
  logic               code_valid_reg, valid_next;
  logic               frame_err_reg, err_next;
  logic               clr_seen_reg, clr_next;
  logic               load_req;
  logic [DATA_W-1:0]  shift_word;

  assign shift_word = {shreg_reg[DATA_W-2:0], sdi_s};

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = bit_cnt_reg;
    code_next  = dac_code_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    clr_next   = 1'b0;
    load_req   = 1'b0;

    if (!clr_n) begin
      // CLR overrides everything, including a pending load or partial frame.
      state_next = S_CLEAR;
      shreg_next = '0;
      cnt_next   = '0;
      code_next  = '0;
      clr_next   = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (ld_fall) begin
            load_req = 1'b1;
          end else if (clk_rise) begin
            shreg_next = shift_word;
            cnt_next   = CNT_W'(1);
            state_next = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (clk_rise) begin
            shreg_next = shift_word;
            cnt_next   = cnt_sat_inc(bit_cnt_reg);
          end
          if (ld_fall) load_req = 1'b1;
        end
        S_LOAD: begin
          if (ld_rise) state_next = S_IDLE;
        end
        S_CLEAR: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase

      // The load looks at the post-shift word and count, so a final CLK
      // rise arriving together with LD is part of the frame.
      if (load_req) begin
        if (cnt_next >= CNT_FULL) begin
          code_next  = shreg_next;
          valid_next = 1'b1;
        end
        if (cnt_next != CNT_FULL) err_next = 1'b1;
        cnt_next   = '0;
        state_next = S_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      shreg_reg      <= '0;
      bit_cnt_reg    <= '0;
      dac_code_reg   <= '0;
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      clr_seen_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      bit_cnt_reg    <= cnt_next;
      dac_code_reg   <= code_next;
      code_valid_reg <= valid_next;
      frame_err_reg  <= err_next;
      clr_seen_reg   <= clr_next;
    end
  end

  assign dac_code   = dac_code_reg;
  assign code_valid = code_valid_reg;
  assign frame_err  = frame_err_reg;
  assign clr_seen   = clr_seen_reg;
  assign bit_cnt    = bit_cnt_reg;

endmodule
